// File: rtl/rv_fetch.sv
// RV64 instruction fetch stage: owns the PC, fills a two-line buffer over a
// req/ack memory port and presents the 64-bit window starting at pc.
module rv_fetch #(
  parameter logic [62:0] RESET_PC = 63'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        advance,
  input  logic [62:0] pcnext,
  output logic        mem_req,
  output logic [60:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_data,
  output logic [62:0] pc,
  output logic [63:0] inst,
  output logic        inst_valid
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [62:0] pc_r, pc_s;
  logic [60:0] tag0_r, tag0_s, tag1_r, tag1_s;
  logic [63:0] data0_r, data0_s, data1_r, data1_s;
  logic        val0_r, val0_s, val1_r, val1_s;
  logic        req_r, req_s;
  logic [60:0] addr_r, addr_s;

  logic [60:0] line_a_s, line_b_s, line_n_s;
  logic        need1_s, hit0_s, hit1_s, valid_s, ack_s, adv_s;
  logic [63:0] window_s;

  // Slot lookup against the current pc and window extraction
  always_comb begin
    line_a_s = pc_r[62:2];
    line_b_s = line_a_s + 61'd1;
    need1_s  = (pc_r[1:0] != 2'd0);
    hit0_s   = val0_r && (tag0_r == line_a_s);
    hit1_s   = val1_r && (tag1_r == line_b_s);
    valid_s  = hit0_s && (!need1_s || hit1_s);
    case (pc_r[1:0])
      2'd0:    window_s = data0_r;
      2'd1:    window_s = {data1_r[15:0], data0_r[63:16]};
      2'd2:    window_s = {data1_r[31:0], data0_r[63:32]};
      2'd3:    window_s = {data1_r[47:0], data0_r[63:48]};
      default: window_s = data0_r;
    endcase
  end

  assign inst       = valid_s ? window_s : 64'd0;
  assign inst_valid = valid_s;
  assign pc         = pc_r;
  assign mem_req    = req_r;
  assign mem_addr   = addr_r;

  // Next state: ack install first, then the advance transform, then the FSM
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    tag0_s   = tag0_r;
    data0_s  = data0_r;
    val0_s   = val0_r;
    tag1_s   = tag1_r;
    data1_s  = data1_r;
    val1_s   = val1_r;
    req_s    = req_r;
    addr_s   = addr_r;
    ack_s    = req_r && mem_ack;
    adv_s    = advance && valid_s;
    line_n_s = pcnext[62:2];

    // A response matching neither needed line is stale after a redirect.
    if (ack_s) begin
      if (addr_r == line_a_s) begin
        tag0_s  = line_a_s;
        data0_s = mem_data;
        val0_s  = 1'b1;
      end else if (addr_r == line_b_s) begin
        tag1_s  = line_b_s;
        data1_s = mem_data;
        val1_s  = 1'b1;
      end else begin
        val0_s = val0_s;
      end
    end else begin
      val0_s = val0_s;
    end

    if (adv_s) begin
      pc_s = pcnext;
      if (line_n_s == line_a_s) begin
        val0_s = val0_s;
      end else if (line_n_s == line_b_s) begin
        tag0_s  = tag1_s;
        data0_s = data1_s;
        val0_s  = val1_s;
        val1_s  = 1'b0;
      end else begin
        val0_s = 1'b0;
        val1_s = 1'b0;
      end
    end else begin
      pc_s = pc_r;
    end

    case (state_r)
      IDLE: begin
        if (!hit0_s) begin
          addr_s  = line_a_s;
          req_s   = 1'b1;
          state_s = REQ;
        end else if (need1_s && !hit1_s) begin
          addr_s  = line_b_s;
          req_s   = 1'b1;
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          req_s   = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = REQ;
        end
      end
      default: begin
        req_s   = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State, PC and line-buffer registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
      tag0_r  <= 61'd0;
      data0_r <= 64'd0;
      val0_r  <= 1'b0;
      tag1_r  <= 61'd0;
      data1_r <= 64'd0;
      val1_r  <= 1'b0;
      req_r   <= 1'b0;
      addr_r  <= 61'd0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      tag0_r  <= tag0_s;
      data0_r <= data0_s;
      val0_r  <= val0_s;
      tag1_r  <= tag1_s;
      data1_r <= data1_s;
      val1_r  <= val1_s;
      req_r   <= req_s;
      addr_r  <= addr_s;
    end
  end

endmodule
